// File: rtl/p_mc_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, opcodes and
// datapath select codes.
package p_mc_pkg;

  localparam int unsigned ST_W  = 4;
  localparam int unsigned OPC_W = 6;

  typedef enum logic [ST_W-1:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_ALUWB  = 4'd7,
    ST_BRANCH = 4'd8,
    ST_IMMEX  = 4'd9,
    ST_IMMWB  = 4'd10,
    ST_JUMP   = 4'd11,
    ST_HALT   = 4'd12
  } state_e;

  localparam logic [OPC_W-1:0] OP_R    = 6'd0;
  localparam logic [OPC_W-1:0] OP_LW   = 6'd35;
  localparam logic [OPC_W-1:0] OP_SW   = 6'd43;
  localparam logic [OPC_W-1:0] OP_BEQ  = 6'd4;
  localparam logic [OPC_W-1:0] OP_ADDI = 6'd8;
  localparam logic [OPC_W-1:0] OP_ORI  = 6'd13;
  localparam logic [OPC_W-1:0] OP_J    = 6'd2;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Datapath strobe bundle produced each cycle by the FSM decode
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/p_mc_timeout.sv
// Memory wait-state counter; flags expiry on the last permitted wait cycle.
module p_mc_timeout #(
  parameter int unsigned LIMIT = 16,
  parameter int unsigned W     = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expired_c) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  // LIMIT of zero means the access may wait forever
  generate
    if (LIMIT == 0) begin : g_no_limit
      assign expired_c = 1'b0;
    end else begin : g_limit
      assign expired_c = (cnt_q == W'(LIMIT - 1));
    end
  endgenerate

endmodule

// File: rtl/p_multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// with a memory ready handshake, bounded wait and sticky bus-error halt.
module p_multicycle_control
  import p_mc_pkg::*;
#(
  parameter int unsigned OP_W          = 6,
  parameter int unsigned ALUOP_W       = 2,
  parameter int unsigned MEM_HANDSHAKE = 1,
  parameter int unsigned MEM_TIMEOUT   = 16,
  parameter int unsigned TMO_W         = 5
) (
  input  logic               P_clk,
  input  logic               P_rst_n,
  input  logic [OP_W-1:0]    P_op,
  input  logic               P_mem_ready,
  output logic               P_PCWrite,
  output logic               P_PCWriteCond,
  output logic               P_IorD,
  output logic               P_MemRead,
  output logic               P_MemWrite,
  output logic               P_IRWrite,
  output logic               P_MemtoReg,
  output logic               P_RegDst,
  output logic               P_RegWrite,
  output logic               P_ALUSrcA,
  output logic [1:0]         P_ALUSrcB,
  output logic [ALUOP_W-1:0] P_ALUOp,
  output logic [1:0]         P_PCSrc,
  output logic [3:0]         P_state,
  output logic               P_illegal,
  output logic               P_bus_error,
  output logic               P_instr_done
);

  localparam int unsigned TMO_LIMIT = (MEM_HANDSHAKE != 0) ? MEM_TIMEOUT : 0;

  state_e           state_q, state_d;
  logic [OPC_W-1:0] op_c, op_q;
  logic             active_q;
  logic             bus_error_q;
  logic             rdy_c;
  logic             tmo_clr_c, tmo_en_c, tmo_expired_c;
  ctrl_t            ctrl_c;

  assign rdy_c = (MEM_HANDSHAKE != 0) ? P_mem_ready : 1'b1;
  assign op_c  = OPC_W'(P_op);

  p_mc_timeout #(
    .LIMIT (TMO_LIMIT),
    .W     (TMO_W)
  ) u_timeout (
    .clk       (P_clk),
    .rst_n     (P_rst_n),
    .clr       (tmo_clr_c),
    .en        (tmo_en_c),
    .expired_c (tmo_expired_c)
  );

  // active_q holds the FSM idle (strobes low) until the first edge after reset
  always_ff @(posedge P_clk or negedge P_rst_n) begin
    if (!P_rst_n) begin
      state_q     <= ST_FETCH;
      op_q        <= '0;
      active_q    <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      active_q <= 1'b1;
      state_q  <= state_d;
      if (active_q && (state_q == ST_DECODE)) begin
        op_q <= op_c;
      end
      if (active_q && (state_d == ST_HALT)) begin
        bus_error_q <= 1'b1;
      end
    end
  end

  // Next-state and strobe decode; memory states may be Mealy on ready
  always_comb begin
    state_d   = state_q;
    ctrl_c    = '0;
    tmo_clr_c = 1'b1;
    tmo_en_c  = 1'b0;
    if (active_q) begin
      case (state_q)
        ST_FETCH: begin
          ctrl_c.mem_read  = 1'b1;
          ctrl_c.alu_src_b = SRCB_4;
          ctrl_c.alu_op    = ALUOP_ADD;
          ctrl_c.pc_src    = PCSRC_ALU;
          ctrl_c.ir_write  = rdy_c;
          ctrl_c.pc_write  = rdy_c;
          tmo_clr_c        = rdy_c;
          tmo_en_c         = !rdy_c;
          if (rdy_c)              state_d = ST_DECODE;
          else if (tmo_expired_c) state_d = ST_HALT;
        end
        ST_DECODE: begin
          ctrl_c.alu_src_b = SRCB_IMMSH;
          ctrl_c.alu_op    = ALUOP_ADD;
          case (op_c)
            OP_R:           state_d = ST_EXEC;
            OP_LW, OP_SW:   state_d = ST_MEMADR;
            OP_BEQ:         state_d = ST_BRANCH;
            OP_ADDI, OP_ORI: state_d = ST_IMMEX;
            OP_J:           state_d = ST_JUMP;
            default: begin
              ctrl_c.illegal    = 1'b1;
              ctrl_c.instr_done = 1'b1;
              state_d           = ST_FETCH;
            end
          endcase
        end
        ST_MEMADR: begin
          ctrl_c.alu_src_a = 1'b1;
          ctrl_c.alu_src_b = SRCB_IMM;
          ctrl_c.alu_op    = ALUOP_ADD;
          state_d          = (op_q == OP_LW) ? ST_MEMRD : ST_MEMWR;
        end
        ST_MEMRD: begin
          ctrl_c.mem_read = 1'b1;
          ctrl_c.iord     = 1'b1;
          tmo_clr_c       = rdy_c;
          tmo_en_c        = !rdy_c;
          if (rdy_c)              state_d = ST_MEMWB;
          else if (tmo_expired_c) state_d = ST_HALT;
        end
        ST_MEMWB: begin
          ctrl_c.mem_to_reg = 1'b1;
          ctrl_c.reg_write  = 1'b1;
          ctrl_c.instr_done = 1'b1;
          state_d           = ST_FETCH;
        end
        ST_MEMWR: begin
          ctrl_c.mem_write  = 1'b1;
          ctrl_c.iord       = 1'b1;
          ctrl_c.instr_done = rdy_c;
          tmo_clr_c         = rdy_c;
          tmo_en_c          = !rdy_c;
          if (rdy_c)              state_d = ST_FETCH;
          else if (tmo_expired_c) state_d = ST_HALT;
        end
        ST_EXEC: begin
          ctrl_c.alu_src_a = 1'b1;
          ctrl_c.alu_src_b = SRCB_B;
          ctrl_c.alu_op    = ALUOP_FUNCT;
          state_d          = ST_ALUWB;
        end
        ST_ALUWB: begin
          ctrl_c.reg_dst    = 1'b1;
          ctrl_c.reg_write  = 1'b1;
          ctrl_c.instr_done = 1'b1;
          state_d           = ST_FETCH;
        end
        ST_BRANCH: begin
          ctrl_c.alu_src_a     = 1'b1;
          ctrl_c.alu_src_b     = SRCB_B;
          ctrl_c.alu_op        = ALUOP_SUB;
          ctrl_c.pc_write_cond = 1'b1;
          ctrl_c.pc_src        = PCSRC_ALUOUT;
          ctrl_c.instr_done    = 1'b1;
          state_d              = ST_FETCH;
        end
        ST_IMMEX: begin
          ctrl_c.alu_src_a = 1'b1;
          ctrl_c.alu_src_b = SRCB_IMM;
          ctrl_c.alu_op    = (op_q == OP_ORI) ? ALUOP_OR : ALUOP_ADD;
          state_d          = ST_IMMWB;
        end
        ST_IMMWB: begin
          ctrl_c.reg_write  = 1'b1;
          ctrl_c.instr_done = 1'b1;
          state_d           = ST_FETCH;
        end
        ST_JUMP: begin
          ctrl_c.pc_write   = 1'b1;
          ctrl_c.pc_src     = PCSRC_JUMP;
          ctrl_c.instr_done = 1'b1;
          state_d           = ST_FETCH;
        end
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_FETCH;
      endcase
    end
  end

  assign P_PCWrite     = ctrl_c.pc_write;
  assign P_PCWriteCond = ctrl_c.pc_write_cond;
  assign P_IorD        = ctrl_c.iord;
  assign P_MemRead     = ctrl_c.mem_read;
  assign P_MemWrite    = ctrl_c.mem_write;
  assign P_IRWrite     = ctrl_c.ir_write;
  assign P_MemtoReg    = ctrl_c.mem_to_reg;
  assign P_RegDst      = ctrl_c.reg_dst;
  assign P_RegWrite    = ctrl_c.reg_write;
  assign P_ALUSrcA     = ctrl_c.alu_src_a;
  assign P_ALUSrcB     = ctrl_c.alu_src_b;
  assign P_ALUOp       = ALUOP_W'(ctrl_c.alu_op);
  assign P_PCSrc       = ctrl_c.pc_src;
  assign P_illegal     = ctrl_c.illegal;
  assign P_instr_done  = ctrl_c.instr_done;
  assign P_state       = 4'(state_q);
  assign P_bus_error   = bus_error_q;

endmodule

// File: tb/tb_p_multicycle_control.sv
// Directed bench for p_multicycle_control: per-cycle state and strobe checks
// across each instruction class, wait states, timeout halt and async reset.
module tb_p_multicycle_control;
  import p_mc_pkg::*;

  logic       P_clk = 1'b0;
  logic       P_rst_n;
  logic [5:0] P_op;
  logic       P_mem_ready;
  logic       P_PCWrite, P_PCWriteCond, P_IorD, P_MemRead, P_MemWrite, P_IRWrite;
  logic       P_MemtoReg, P_RegDst, P_RegWrite, P_ALUSrcA;
  logic [1:0] P_ALUSrcB, P_ALUOp, P_PCSrc;
  logic [3:0] P_state;
  logic       P_illegal, P_bus_error, P_instr_done;
  logic [17:0] obs;

  int n_chk  = 0;
  int n_pass = 0;

  // {pcw,pcwc,iord,mrd,mwr,irw}_{m2r,rdst,rw,asa}_{asb}_{aop}_{pcs}_{ill,done}
  localparam logic [17:0] S_ZERO      = 18'b000000_0000_00_00_00_00;
  localparam logic [17:0] S_FETCH_R   = 18'b100101_0000_01_00_00_00;
  localparam logic [17:0] S_FETCH_W   = 18'b000100_0000_01_00_00_00;
  localparam logic [17:0] S_DECODE    = 18'b000000_0000_11_00_00_00;
  localparam logic [17:0] S_DEC_ILL   = 18'b000000_0000_11_00_00_11;
  localparam logic [17:0] S_MEMADR    = 18'b000000_0001_10_00_00_00;
  localparam logic [17:0] S_MEMRD     = 18'b001100_0000_00_00_00_00;
  localparam logic [17:0] S_MEMWB     = 18'b000000_1010_00_00_00_01;
  localparam logic [17:0] S_MEMWR_W   = 18'b001010_0000_00_00_00_00;
  localparam logic [17:0] S_MEMWR_R   = 18'b001010_0000_00_00_00_01;
  localparam logic [17:0] S_EXEC      = 18'b000000_0001_00_10_00_00;
  localparam logic [17:0] S_ALUWB     = 18'b000000_0110_00_00_00_01;
  localparam logic [17:0] S_BRANCH    = 18'b010000_0001_00_01_01_01;
  localparam logic [17:0] S_IMMEX_OR  = 18'b000000_0001_10_11_00_00;
  localparam logic [17:0] S_IMMEX_ADD = 18'b000000_0001_10_00_00_00;
  localparam logic [17:0] S_IMMWB     = 18'b000000_0010_00_00_00_01;
  localparam logic [17:0] S_JUMP      = 18'b100000_0000_00_00_10_01;

  p_multicycle_control #(
    .OP_W          (6),
    .ALUOP_W       (2),
    .MEM_HANDSHAKE (1),
    .MEM_TIMEOUT   (8),
    .TMO_W         (5)
  ) dut (
    .P_clk         (P_clk),
    .P_rst_n       (P_rst_n),
    .P_op          (P_op),
    .P_mem_ready   (P_mem_ready),
    .P_PCWrite     (P_PCWrite),
    .P_PCWriteCond (P_PCWriteCond),
    .P_IorD        (P_IorD),
    .P_MemRead     (P_MemRead),
    .P_MemWrite    (P_MemWrite),
    .P_IRWrite     (P_IRWrite),
    .P_MemtoReg    (P_MemtoReg),
    .P_RegDst      (P_RegDst),
    .P_RegWrite    (P_RegWrite),
    .P_ALUSrcA     (P_ALUSrcA),
    .P_ALUSrcB     (P_ALUSrcB),
    .P_ALUOp       (P_ALUOp),
    .P_PCSrc       (P_PCSrc),
    .P_state       (P_state),
    .P_illegal     (P_illegal),
    .P_bus_error   (P_bus_error),
    .P_instr_done  (P_instr_done)
  );

  always #5 P_clk = ~P_clk;

  assign obs = {P_PCWrite, P_PCWriteCond, P_IorD, P_MemRead, P_MemWrite, P_IRWrite,
                P_MemtoReg, P_RegDst, P_RegWrite, P_ALUSrcA,
                P_ALUSrcB, P_ALUOp, P_PCSrc, P_illegal, P_instr_done};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One FSM cycle: drive inputs at the falling edge, then check state and strobes
  task automatic cyc(input string tag, input logic rdy, input logic [5:0] op,
                     input logic [3:0] exp_st, input logic [17:0] exp_sv);
    @(negedge P_clk);
    P_mem_ready = rdy;
    P_op        = op;
    #1;
    check({tag, "_st"}, 32'(P_state), 32'(exp_st));
    check(tag, 32'(obs), 32'(exp_sv));
  endtask

  initial begin
    P_rst_n     = 1'b0;
    P_op        = 6'd0;
    P_mem_ready = 1'b0;
    repeat (2) @(posedge P_clk);
    @(negedge P_clk);
    #1;
    check("rst_st", 32'(P_state), 32'(ST_FETCH));
    check("rst_sv", 32'(obs), 32'(S_ZERO));
    check("rst_berr", 32'(P_bus_error), 32'd0);
    P_rst_n = 1'b1;

    // R-type, preceded by one fetch wait state
    cyc("r_fw",  1'b0, 6'd0, 4'(ST_FETCH),  S_FETCH_W);
    cyc("r_f",   1'b1, 6'd0, 4'(ST_FETCH),  S_FETCH_R);
    cyc("r_d",   1'b1, 6'd0, 4'(ST_DECODE), S_DECODE);
    cyc("r_ex",  1'b1, 6'd0, 4'(ST_EXEC),   S_EXEC);
    cyc("r_wb",  1'b1, 6'd0, 4'(ST_ALUWB),  S_ALUWB);

    // lw with two read wait states
    cyc("lw_f",  1'b1, 6'd35, 4'(ST_FETCH),  S_FETCH_R);
    cyc("lw_d",  1'b1, 6'd35, 4'(ST_DECODE), S_DECODE);
    cyc("lw_a",  1'b1, 6'd35, 4'(ST_MEMADR), S_MEMADR);
    cyc("lw_r0", 1'b0, 6'd35, 4'(ST_MEMRD),  S_MEMRD);
    cyc("lw_r1", 1'b0, 6'd35, 4'(ST_MEMRD),  S_MEMRD);
    cyc("lw_r2", 1'b1, 6'd35, 4'(ST_MEMRD),  S_MEMRD);
    cyc("lw_wb", 1'b1, 6'd35, 4'(ST_MEMWB),  S_MEMWB);

    // beq
    cyc("bq_f",  1'b1, 6'd4, 4'(ST_FETCH),  S_FETCH_R);
    cyc("bq_d",  1'b1, 6'd4, 4'(ST_DECODE), S_DECODE);
    cyc("bq_b",  1'b1, 6'd4, 4'(ST_BRANCH), S_BRANCH);

    // ori; opcode input changes after decode, latched value must steer IMMEX
    cyc("or_f",  1'b1, 6'd13, 4'(ST_FETCH),  S_FETCH_R);
    cyc("or_d",  1'b1, 6'd13, 4'(ST_DECODE), S_DECODE);
    cyc("or_x",  1'b1, 6'd8,  4'(ST_IMMEX),  S_IMMEX_OR);
    cyc("or_wb", 1'b1, 6'd8,  4'(ST_IMMWB),  S_IMMWB);

    // addi
    cyc("ad_f",  1'b1, 6'd8, 4'(ST_FETCH),  S_FETCH_R);
    cyc("ad_d",  1'b1, 6'd8, 4'(ST_DECODE), S_DECODE);
    cyc("ad_x",  1'b1, 6'd8, 4'(ST_IMMEX),  S_IMMEX_ADD);
    cyc("ad_wb", 1'b1, 6'd8, 4'(ST_IMMWB),  S_IMMWB);

    // j
    cyc("j_f",   1'b1, 6'd2, 4'(ST_FETCH),  S_FETCH_R);
    cyc("j_d",   1'b1, 6'd2, 4'(ST_DECODE), S_DECODE);
    cyc("j_j",   1'b1, 6'd2, 4'(ST_JUMP),   S_JUMP);

    // illegal opcode returns straight to fetch
    cyc("il_f",  1'b1, 6'd63, 4'(ST_FETCH),  S_FETCH_R);
    cyc("il_d",  1'b1, 6'd63, 4'(ST_DECODE), S_DEC_ILL);
    cyc("il_f2", 1'b1, 6'd63, 4'(ST_FETCH),  S_FETCH_R);

    // sw with one write wait state
    cyc("sw_d",  1'b1, 6'd43, 4'(ST_DECODE), S_DECODE);
    cyc("sw_a",  1'b1, 6'd43, 4'(ST_MEMADR), S_MEMADR);
    cyc("sw_w0", 1'b0, 6'd43, 4'(ST_MEMWR),  S_MEMWR_W);
    cyc("sw_w1", 1'b1, 6'd43, 4'(ST_MEMWR),  S_MEMWR_R);

    // lw: ready arrives exactly on the timeout limit cycle and wins
    cyc("lwb_f", 1'b1, 6'd35, 4'(ST_FETCH),  S_FETCH_R);
    cyc("lwb_d", 1'b1, 6'd35, 4'(ST_DECODE), S_DECODE);
    cyc("lwb_a", 1'b1, 6'd35, 4'(ST_MEMADR), S_MEMADR);
    for (int i = 0; i < 7; i++) cyc("lwb_rw", 1'b0, 6'd35, 4'(ST_MEMRD), S_MEMRD);
    cyc("lwb_rr", 1'b1, 6'd35, 4'(ST_MEMRD), S_MEMRD);
    cyc("lwb_wb", 1'b1, 6'd35, 4'(ST_MEMWB), S_MEMWB);
    check("lwb_berr", 32'(P_bus_error), 32'd0);

    // sw timeout: eight unanswered write cycles, then HALT
    cyc("to_f",  1'b1, 6'd43, 4'(ST_FETCH),  S_FETCH_R);
    cyc("to_d",  1'b1, 6'd43, 4'(ST_DECODE), S_DECODE);
    cyc("to_a",  1'b1, 6'd43, 4'(ST_MEMADR), S_MEMADR);
    for (int i = 0; i < 8; i++) cyc("to_w", 1'b0, 6'd43, 4'(ST_MEMWR), S_MEMWR_W);
    check("to_berr_pre", 32'(P_bus_error), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc("to_halt", 1'b1, 6'd0, 4'(ST_HALT), S_ZERO);
      check("to_berr", 32'(P_bus_error), 32'd1);
    end

    // reset pulse leaves HALT and clears bus error
    @(negedge P_clk);
    P_rst_n = 1'b0;
    #1;
    check("hr_st", 32'(P_state), 32'(ST_FETCH));
    check("hr_berr", 32'(P_bus_error), 32'd0);
    @(negedge P_clk);
    P_rst_n = 1'b1;
    cyc("hr_f",  1'b1, 6'd43, 4'(ST_FETCH),  S_FETCH_R);
    cyc("hr_d",  1'b1, 6'd43, 4'(ST_DECODE), S_DECODE);
    cyc("hr_a",  1'b1, 6'd43, 4'(ST_MEMADR), S_MEMADR);
    cyc("hr_w",  1'b0, 6'd43, 4'(ST_MEMWR),  S_MEMWR_W);

    // reset mid-write: strobe must drop without waiting for a clock edge
    #1 P_rst_n = 1'b0;
    #1;
    check("mr_mwr", 32'(P_MemWrite), 32'd0);
    check("mr_sv", 32'(obs), 32'(S_ZERO));
    check("mr_st", 32'(P_state), 32'(ST_FETCH));
    @(negedge P_clk);
    P_rst_n = 1'b1;
    cyc("mr_f",  1'b1, 6'd0, 4'(ST_FETCH), S_FETCH_R);
    check("mr_berr", 32'(P_bus_error), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
